// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: funct3 codes, FSM states, error and write-enable codes.
// Also holds the request-legality helpers used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    localparam logic [1:0] MEM_WE_NONE = 2'b00;
    localparam logic [1:0] MEM_WE_WORD = 2'b01;

    // Stores have no unsigned variants, so funct3[2] is illegal for them.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = |lane;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and merges
// byte/half store data into an old word. No state, no backpressure.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_o = '0;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            F3_W:    load_o = word_i;
            default: load_o = '0;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (funct3_i[1:0])
            2'b00: merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            2'b01: begin
                if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
                else           merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store controller in front of a word-wide data memory; RMW for SB/SH.
// Accept->rsp latency: error 1, load/SW 2, SB/SH 3; one request in flight, req_ready only in IDLE.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wword,
    output logic [7:0]  mem_wbyte,
    output logic [1:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;

    logic [32:0] offset;
    logic        out_of_range;
    logic [1:0]  accept_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // 33-bit subtraction so addresses below the window borrow instead of wrapping into it.
    assign offset       = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign out_of_range = offset[32] || (offset >= MEM_LIMIT);

    always_comb begin
        accept_err = ERR_OK;
        if (f3_illegal(req_we, req_funct3))             accept_err = ERR_FUNCT3;
        else if (out_of_range)                          accept_err = ERR_RANGE;
        else if (misaligned(req_funct3, req_addr[1:0])) accept_err = ERR_MISALIGN;
    end

    lsu_align u_align (
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .lane_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .load_o   (load_data),
        .merge_o  (merged_word)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = accept_err;
                    rdata_d  = '0;
                    if (req_we) word_d = req_wdata;
                    if (accept_err != ERR_OK)          state_d = ST_RESP;
                    else if (req_we && req_funct3 == F3_W) state_d = ST_WR;
                    else                               state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (we_q) begin
                    word_d  = merged_word;
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wword = word_q;
    assign mem_wbyte = 8'h00;
    assign mem_we    = (state_q == ST_WR) ? MEM_WE_WORD : MEM_WE_NONE;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized and directed bench for lsu_mem_ctrl against a word-array reference model.
module tb_lsu_mem_ctrl;

    localparam logic [31:0] BASE  = 32'hFFFF0000;
    localparam int unsigned MEMB  = 65536;
    localparam int          WORDS = MEMB / 4;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wword;
    logic [7:0]  mem_wbyte;
    logic [1:0]  mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] tmem    [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic        bd_vld;
    logic [13:0] bd_idx;
    logic [31:0] bd_dat;

    int checks   = 0;
    int failures = 0;

    lsu_mem_ctrl #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wword  (mem_wword),
        .mem_wbyte  (mem_wbyte),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment memory: combinational read, word write on the clock edge.
    assign mem_rdata = tmem[mem_addr[15:2]];
    always @(posedge CLK) begin
        if (mem_we == 2'b01) tmem[mem_addr[15:2]] <= mem_wword;
        else if (bd_vld)     tmem[bd_idx] <= bd_dat;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'(o >> 2);
    endfunction

    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [1:0] err,
                                  output logic [31:0] rdata, output int lat, output bit wr,
                                  output logic [31:0] wword);
        bit [63:0]   a64;
        bit          illegal, inr, mis;
        int          sz, sh;
        logic [31:0] old, v, mask;
        a64     = {32'h0, addr};
        illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
        inr     = (a64 >= {32'h0, BASE}) && (a64 < {32'h0, BASE} + 64'(MEMB));
        sz      = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        mis     = (addr % sz) != 0;
        err     = illegal ? 2'd3 : !inr ? 2'd2 : mis ? 2'd1 : 2'd0;
        rdata   = 0;
        wr      = 0;
        wword   = 0;
        lat     = 1;
        if (err == 0) begin
            old = ref_mem[widx(addr)];
            sh  = (addr % 4) * 8;
            if (!we) begin
                lat = 2;
                if (sz == 4) rdata = old;
                else begin
                    v = (old >> sh) & ((sz == 1) ? 32'hFF : 32'hFFFF);
                    if (f3 < 4 && v >= ((sz == 1) ? 32'h80 : 32'h8000))
                        v = v | ((sz == 1) ? 32'hFFFFFF00 : 32'hFFFF0000);
                    rdata = v;
                end
            end else begin
                lat   = (sz == 4) ? 2 : 3;
                wr    = 1;
                mask  = (sz == 4) ? 32'hFFFFFFFF : (((sz == 1) ? 32'hFF : 32'hFFFF) << sh);
                wword = (old & ~mask) | ((wdata << sh) & mask);
            end
        end
    endfunction

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
        logic [1:0]  e_err;
        logic [31:0] e_rd, e_ww, aligned;
        int          e_lat, nwr, w;
        bit          e_wr, got;
        model(we, f3, addr, wdata, e_err, e_rd, e_lat, e_wr, e_ww);
        aligned = {addr[31:2], 2'b00};
        @(negedge CLK);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge CLK);
            w++;
        end
        if (!req_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        nwr = 0;
        got = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                check_eq("ready_busy", 32'(req_ready), 32'd0);
                if (!hold) req_valid = 1'b0;
            end
            if (mem_we == 2'b01) begin
                nwr++;
                check_eq("wr_word", mem_wword, e_ww);
                check_eq("wr_addr", mem_addr, aligned);
            end else if (mem_we != 2'b00) begin
                check_eq("mem_we_code", 32'(mem_we), 32'd0);
            end
            if (e_err == 0 && !rsp_valid) check_eq("mem_addr_hold", mem_addr, aligned);
            if (rsp_valid) begin
                got = 1;
                check_eq("latency", 32'(c), 32'(e_lat));
                check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
                check_eq("rsp_rdata", rsp_rdata, e_rd);
            end
        end
        if (!got) check_eq("rsp_timeout", 32'd0, 32'd1);
        check_eq("n_writes", 32'(nwr), 32'(e_wr));
        if (e_wr) ref_mem[widx(addr)] = e_ww;
        if (!hold) begin
            @(negedge CLK);
            check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic rand_req(input bit hold);
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [2:0]  legal [5];
        legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        case ($urandom % 6)
            0:       addr = $urandom_range(0, 32'hFFFEFFFF);
            1:       addr = BASE - 1 - $urandom_range(0, 7);
            2:       addr = 32'hFFFFFF00 + $urandom_range(0, 255);
            default: addr = BASE + $urandom_range(0, 255);
        endcase
        if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
        else                   f3 = legal[$urandom % 5];
        do_req(1'($urandom % 2), f3, addr, $urandom, hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; bd_vld = 1'b0; bd_idx = '0; bd_dat = '0;
        // Preload the two regions the stimulus touches (low and top of the window).
        for (int k = 0; k < 128; k++) begin
            idx = (k < 64) ? k : 16320 + k - 64;
            @(negedge CLK);
            bd_vld = 1'b1; bd_idx = 14'(idx); bd_dat = $urandom;
            ref_mem[idx] = bd_dat;
        end
        @(negedge CLK);
        bd_vld = 1'b0;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wword", mem_wword, 32'd0);
        check_eq("rst_mem_wbyte", 32'(mem_wbyte), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);

        do_req(1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, 0);
        do_req(0, 3'b010, BASE + 32'h10, 32'h0, 0);
        do_req(1, 3'b010, BASE + 32'h20, 32'h11228344, 0);
        do_req(0, 3'b000, BASE + 32'h21, 32'h0, 0);
        do_req(0, 3'b100, BASE + 32'h21, 32'h0, 0);
        do_req(0, 3'b000, BASE + 32'h22, 32'h0, 0);
        do_req(0, 3'b001, BASE + 32'h22, 32'h0, 0);
        do_req(0, 3'b101, BASE + 32'h20, 32'h0, 0);
        do_req(1, 3'b010, BASE + 32'h20, 32'h11223344, 0);
        do_req(1, 3'b000, BASE + 32'h21, 32'h000000AB, 0);
        do_req(0, 3'b010, BASE + 32'h20, 32'h0, 0);
        do_req(1, 3'b010, BASE + 32'h20, 32'h11223344, 0);
        do_req(1, 3'b001, BASE + 32'h22, 32'h0000BEEF, 0);
        do_req(0, 3'b010, BASE + 32'h20, 32'h0, 0);
        do_req(0, 3'b010, BASE + 32'h2,  32'h0, 0);
        do_req(1, 3'b010, 32'h00001000,  32'h12345678, 0);
        do_req(0, 3'b011, BASE + 32'h10, 32'h0, 0);
        do_req(1, 3'b100, BASE + 32'h10, 32'h0, 0);
        do_req(0, 3'b010, 32'hFFFFFFFC, 32'h0, 0);
        do_req(1, 3'b010, 32'hFFFFFFFC, 32'hA5A5C3C3, 0);
        do_req(0, 3'b010, 32'hFFFFFFFC, 32'h0, 0);
        do_req(0, 3'b001, 32'hFFFFFFFE, 32'h0, 0);
        do_req(0, 3'b010, 32'hFFFFFFFE, 32'h0, 0);
        do_req(0, 3'b010, 32'hFFFEFFFC, 32'h0, 0);
        do_req(0, 3'b010, BASE,         32'h0, 0);

        // Abort an SB in its write cycle: the old word must survive.
        do_req(1, 3'b010, BASE + 32'h40, 32'hCAFEF00D, 0);
        @(negedge CLK);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = BASE + 32'h41; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        check_eq("abort_we_before", 32'(mem_we), 32'd1);
        RST_N = 1'b0;
        #1;
        check_eq("abort_we_drop", 32'(mem_we), 32'd0);
        check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check_eq("abort_quiet", 32'(rsp_valid), 32'd0);
        end
        RST_N = 1'b1;
        do_req(0, 3'b010, BASE + 32'h40, 32'h0, 0);

        for (int i = 0; i < 10; i++) rand_req(i < 9);
        for (int i = 0; i < 300; i++) rand_req((i < 299) ? 1'($urandom % 2) : 1'b0);
        req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
